// File: rtl/ad_scan_avg_ctrl.sv
// Multi-channel SPI-style ADC scanner with per-channel averaging and mV scaling.
// Define BCD_OUT_EN to add volts/tenths digit outputs from a sequential converter.
module ad_scan_avg_ctrl #(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned CH_NUM     = 8,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned VREF_MV    = 3300,
  parameter int unsigned CS_HIGH    = 50
) (
  input  logic              CLK_50M,
  input  logic              RST,
  input  logic              i_en,
  output logic              AD_CS,
  output logic              AD_CLK,
  output logic              AD_DIN,
  input  logic              AD_DATA,
  output logic              o_valid,
  output logic [2:0]        o_ch,
  output logic [DATA_W-1:0] o_code,
  output logic [13:0]       o_mv
`ifdef BCD_OUT_EN
  ,
  output logic [3:0]        o_vol_int,
  output logic [3:0]        o_vol_dec
`endif
);

  localparam int unsigned CNT_MAX = (CLK_DIV > CS_HIGH) ? CLK_DIV : CS_HIGH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned BIT_W   = $clog2(FRAME_BITS);
  localparam int unsigned ACC_W   = DATA_W + AVG_LOG2;
  localparam int unsigned SC_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned SAMP    = 1 << AVG_LOG2;
  localparam int unsigned PRD_W   = DATA_W + 14;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [BIT_W-1:0]    bit_idx, bit_nxt;
  logic                cnt_done, frame_end, rise, fall;
  logic [DATA_W-1:0]   shreg;

  logic                primed;
  logic [2:0]          rx_ch, ch_inc, tx_ch, res_ch;
  logic [SC_W-1:0]     rx_cnt;
  logic                rx_last;
  logic [ACC_W-1:0]    accum, acc_sum;
  logic [DATA_W-1:0]   avg_val, res_avg;
  logic [PRD_W-1:0]    prod;
  logic [13:0]         mv_r;
  logic                p1, p2;

  function automatic logic din_bit(input logic [BIT_W-1:0] idx, input logic [2:0] a);
    if (idx == BIT_W'(2)) return a[2];
    if (idx == BIT_W'(3)) return a[1];
    if (idx == BIT_W'(4)) return a[0];
    return 1'b0;
  endfunction

  always_comb begin
    cnt_done  = (state == GAP) ? (cnt == CNT_W'(CS_HIGH - 1)) : (cnt == CNT_W'(CLK_DIV - 1));
    frame_end = (state == SHIFT) && cnt_done && AD_CLK && (bit_idx == BIT_W'(FRAME_BITS - 1));
    rise      = (state == SHIFT) && cnt_done && !AD_CLK;
    fall      = (state == SHIFT) && cnt_done && AD_CLK && !frame_end;
    bit_nxt   = bit_idx + BIT_W'(1);
    state_nxt = state;
    case (state)
      IDLE:    if (i_en) state_nxt = SETUP;
      SETUP:   if (cnt_done) state_nxt = SHIFT;
      SHIFT:   if (frame_end) state_nxt = GAP;
      GAP:     if (cnt_done) state_nxt = i_en ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The address sent now selects the channel whose data returns next frame.
  always_comb begin
    rx_last = (rx_cnt == SC_W'(SAMP - 1));
    ch_inc  = (rx_ch == 3'(CH_NUM - 1)) ? 3'd0 : rx_ch + 3'd1;
    tx_ch   = !primed ? 3'd0 : (rx_last ? ch_inc : rx_ch);
    acc_sum = ((rx_cnt == '0) ? '0 : accum) + ACC_W'(shreg);
    avg_val = DATA_W'(acc_sum >> AVG_LOG2);
    prod    = PRD_W'(res_avg) * PRD_W'(VREF_MV);
  end

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      cnt     <= '0;
      bit_idx <= '0;
      AD_CS   <= 1'b1;
      AD_CLK  <= 1'b0;
      AD_DIN  <= 1'b0;
      shreg   <= '0;
    end else begin
      if (state == IDLE || state_nxt != state || cnt_done) cnt <= '0;
      else                                                 cnt <= cnt + CNT_W'(1);
      AD_CS <= (state_nxt == IDLE) || (state_nxt == GAP);
      if (state == SHIFT && cnt_done) AD_CLK <= ~AD_CLK;
      else if (state != SHIFT)        AD_CLK <= 1'b0;
      if (state != SHIFT)  bit_idx <= '0;
      else if (fall)       bit_idx <= bit_nxt;
      if (fall)                              AD_DIN <= din_bit(bit_nxt, tx_ch);
      else if (frame_end || state != SHIFT)  AD_DIN <= 1'b0;
      if (rise) shreg <= {shreg[DATA_W-2:0], AD_DATA};
    end
  end

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      primed  <= 1'b0;
      rx_ch   <= '0;
      rx_cnt  <= '0;
      accum   <= '0;
      res_avg <= '0;
      res_ch  <= '0;
      mv_r    <= '0;
      p1      <= 1'b0;
      p2      <= 1'b0;
    end else begin
      p1 <= frame_end && primed && rx_last;
      p2 <= p1;
      if (p1) mv_r <= 14'(prod >> DATA_W);
      if (state == IDLE) begin
        primed <= 1'b0;
        rx_ch  <= '0;
        rx_cnt <= '0;
        accum  <= '0;
      end else if (frame_end) begin
        primed <= 1'b1;
        if (primed) begin
          accum  <= acc_sum;
          rx_ch  <= tx_ch;
          rx_cnt <= rx_last ? '0 : rx_cnt + SC_W'(1);
          if (rx_last) begin
            res_avg <= avg_val;
            res_ch  <= rx_ch;
          end
        end
      end
    end
  end

`ifdef BCD_OUT_EN
  logic [13:0] rem;
  logic [3:0]  vi, vd;
  logic        busy, phase;

  // Repeated subtraction: thousands first, then hundreds; outputs publish together.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      rem <= '0; vi <= '0; vd <= '0; busy <= 1'b0; phase <= 1'b0;
      o_valid <= 1'b0; o_ch <= '0; o_code <= '0; o_mv <= '0;
      o_vol_int <= '0; o_vol_dec <= '0;
    end else begin
      o_valid <= 1'b0;
      if (p2) begin
        rem <= mv_r; vi <= '0; vd <= '0; busy <= 1'b1; phase <= 1'b0;
      end else if (busy) begin
        if (!phase) begin
          if (rem >= 14'd1000) begin
            rem <= rem - 14'd1000;
            vi  <= vi + 4'd1;
          end else begin
            phase <= 1'b1;
          end
        end else if (rem >= 14'd100) begin
          rem <= rem - 14'd100;
          vd  <= vd + 4'd1;
        end else begin
          busy      <= 1'b0;
          o_valid   <= 1'b1;
          o_ch      <= res_ch;
          o_code    <= res_avg;
          o_mv      <= mv_r;
          o_vol_int <= vi;
          o_vol_dec <= vd;
        end
      end
    end
  end
`else
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      o_valid <= 1'b0; o_ch <= '0; o_code <= '0; o_mv <= '0;
    end else begin
      o_valid <= p2;
      if (p2) begin
        o_ch   <= res_ch;
        o_code <= res_avg;
        o_mv   <= mv_r;
      end
    end
  end
`endif

endmodule
